axis_framer: RTL and testbench

- AXI-Stream transmit-side framer: accepts a continuous sample stream and emits it as framed packets, generating m_axis_tlast every frame_len beats or earlier on an upstream s_axis_tlast.
- Sits at the tail of a sample-processing chain, ahead of the packet consumer (DMA/host bridge).
- Honours full AXIS backpressure through a 2-entry skid buffer, giving one beat per cycle with a registered s_axis_tready.

---
 rtl/axis_pkg.sv | 9 +
 rtl/axis_skid_buffer.sv | 37 +++
 rtl/axis_framer.sv | 64 ++++++
 tb/tb_axis_framer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared framer state, default widths and tkeep width helper
package axis_pkg;
  typedef enum logic {ST_IDLE, ST_IN_FRAME} framer_state_e;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH = 16;
  function automatic int keep_width(input int dw);
    return (dw + 7) / 8;
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: output register plus one skid entry, registered s_ready
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);
  logic [W-1:0] skid_q;
  logic         skid_valid;
  logic         accept;
  assign accept = s_valid & s_ready;
  // refill the output from skid first, else straight from the input; park in skid only when output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
      s_ready    <= 1'b0;
    end else if (!m_valid || m_ready) begin
      m_valid    <= skid_valid | accept;
      m_data     <= skid_valid ? skid_q : accept ? s_data : m_data;
      skid_valid <= 1'b0;
      s_ready    <= 1'b1;
    end else if (accept) begin
      skid_q     <= s_data;
      skid_valid <= 1'b1;
      s_ready    <= 1'b0;
    end
  end
endmodule

// File: rtl/axis_framer.sv
// axis_framer: frames an AXIS sample stream, tlast every frame_len beats or on upstream tlast
module axis_framer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = keep_width(DATA_WIDTH),
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic                  in_frame
);
  localparam int W = DATA_WIDTH + KEEP_WIDTH + 1;
  framer_state_e        state;
  logic [LEN_WIDTH-1:0] cnt, len_q, eff_len, cnt_inc;
  logic                 accept, last;
  logic [W-1:0]         out_word;
  assign accept = s_axis_tvalid & s_axis_tready;
  assign in_frame = state == ST_IN_FRAME;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_word;
  // a zero length is treated as one-beat frames; last is decided on the input side
  always_comb begin
    eff_len = frame_len == '0 ? LEN_WIDTH'(1) : frame_len;
    cnt_inc = cnt + LEN_WIDTH'(1);
    last    = s_axis_tlast | (state == ST_IDLE ? eff_len == LEN_WIDTH'(1) : cnt_inc == len_q);
  end
  // framing FSM: length latched on the first beat, beat counter and completed-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      len_q       <= '0;
      frame_count <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) len_q <= eff_len;
      cnt         <= last ? '0 : state == ST_IDLE ? LEN_WIDTH'(1) : cnt_inc;
      state       <= last ? ST_IDLE : ST_IN_FRAME;
      frame_count <= last ? frame_count + CNT_WIDTH'(1) : frame_count;
    end
  end
  axis_skid_buffer #(.W(W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({last, s_axis_tkeep, s_axis_tdata}),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (out_word),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );
endmodule

// File: tb/tb_axis_framer.sv
// tb_axis_framer: table-driven framing checks plus backpressure, reset and wrap sequences
module tb_axis_framer;
  typedef struct {
    int         t;
    logic [7:0] d;
    logic       sl;
    logic [15:0] fl;
    logic       el;
  } vec_t;
  typedef struct {
    logic [7:0] d;
    logic       k;
    logic       l;
    int         c;
  } obs_t;
  logic        clk, rst;
  logic [7:0]  s_tdata, m_tdata;
  logic        s_tkeep, m_tkeep;
  logic        s_tvalid, s_tready, s_tlast;
  logic        m_tvalid, m_tready, m_tlast;
  logic [15:0] frame_len;
  logic [3:0]  frame_count;
  logic        in_frame;
  int          checks = 0, failures = 0, cyc = 0, mode = 0;
  vec_t        vt[$];
  obs_t        outq[$];
  int          accq[$];
  axis_framer #(.CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .frame_len(frame_len), .frame_count(frame_count), .in_frame(in_frame)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(posedge clk);
    #1;
    m_tready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'b0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void add(input int t, input int d, input logic sl, input int fl, input logic el);
    vt.push_back('{t, 8'(d), sl, 16'(fl), el});
  endfunction
  // cycle monitor: occupancy model for ready/valid, output hold while stalled, transfer logging
  initial begin
    int occ = 0, post = 0;
    logic stall = 0, hl = 0, ia, oa;
    logic [7:0] hd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        occ = 0;
        post = 0;
        stall = 0;
      end else begin
        if (post > 0) begin
          chk("s_tready", 32'(s_tready), 32'(occ < 2));
          chk("m_tvalid", 32'(m_tvalid), 32'(occ != 0));
          if (stall && m_tvalid) begin
            chk("hold_data", 32'(m_tdata), 32'(hd));
            chk("hold_last", 32'(m_tlast), 32'(hl));
          end
        end
        post++;
        ia = s_tvalid & s_tready;
        oa = m_tvalid & m_tready;
        if (ia) accq.push_back(cyc);
        if (oa) outq.push_back('{m_tdata, m_tkeep, m_tlast, cyc});
        stall = m_tvalid & !m_tready;
        hd = m_tdata;
        hl = m_tlast;
        occ += int'(ia) - int'(oa);
      end
    end
  end
  task automatic do_reset();
    rst = 1;
    s_tvalid = 0;
    s_tlast = 0;
    mode = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_m_tdata", 32'(m_tdata), 0);
    chk("rst_m_tkeep_last", 32'({m_tkeep, m_tlast}), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_in_frame", 32'(in_frame), 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic send(input logic [7:0] d, input logic sl, input logic [15:0] fl);
    logic acc;
    int g = 0;
    s_tvalid = 1;
    s_tdata = d;
    s_tkeep = d[0];
    s_tlast = sl;
    frame_len = fl;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 64);
    if (!acc) chk("accept_timeout", 0, 1);
    s_tvalid = 0;
    s_tlast = 0;
  endtask
  task automatic run_test(input int t, input int md, input int efc, input logic eif);
    int idx[$];
    int g = 0;
    do_reset();
    outq.delete();
    accq.delete();
    mode = md;
    m_tready = md != 2;
    foreach (vt[i]) if (vt[i].t == t) idx.push_back(i);
    foreach (idx[k]) send(vt[idx[k]].d, vt[idx[k]].sl, vt[idx[k]].fl);
    while (outq.size() < idx.size() && g < 100) begin
      @(posedge clk);
      g++;
    end
    @(negedge clk);
    chk($sformatf("t%0d_out_count", t), 32'(outq.size()), 32'(idx.size()));
    foreach (idx[k]) if (k < outq.size()) begin
      chk($sformatf("t%0d_data%0d", t, k), 32'(outq[k].d), 32'(vt[idx[k]].d));
      chk($sformatf("t%0d_last%0d", t, k), 32'({outq[k].k, outq[k].l}), 32'({vt[idx[k]].d[0], vt[idx[k]].el}));
      if (t == 1 && k < accq.size()) chk($sformatf("t1_latency%0d", k), 32'(outq[k].c - accq[k]), 1);
    end
    chk($sformatf("t%0d_frame_count", t), 32'(frame_count), 32'(efc));
    chk($sformatf("t%0d_in_frame", t), 32'(in_frame), 32'(eif));
  endtask
  initial begin
    rst = 1;
    s_tvalid = 0;
    s_tlast = 0;
    s_tdata = 0;
    s_tkeep = 0;
    m_tready = 1;
    frame_len = 0;
    for (int i = 1; i <= 10; i++) add(1, i, 0, 4, i % 4 == 0);
    for (int i = 1; i <= 9; i++) add(2, i, 0, 3, i % 3 == 0);
    for (int i = 1; i <= 11; i++) add(3, i, i == 3, 8, i == 3 || i == 11);
    for (int i = 1; i <= 8; i++) add(4, i, 0, i == 1 ? 4 : 2, i == 4 || i == 6 || i == 8);
    for (int i = 1; i <= 5; i++) add(5, 'h20 + i, 0, 0, 1);
    for (int i = 1; i <= 4; i++) add(6, 'h10 + i, 0, 4, i == 4);
    for (int i = 1; i <= 17; i++) add(7, 'h40 + i, 0, 1, 1);
    run_test(1, 0, 2, 1);
    run_test(2, 1, 3, 0);
    run_test(3, 0, 2, 0);
    run_test(4, 0, 3, 0);
    run_test(5, 0, 5, 0);
    do_reset();
    mode = 2;
    m_tready = 0;
    send(8'h01, 0, 4);
    send(8'h02, 0, 4);
    @(negedge clk);
    chk("t6_pre_in_frame", 32'(in_frame), 1);
    chk("t6_pre_s_tready", 32'(s_tready), 0);
    run_test(6, 0, 1, 0);
    run_test(7, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
